sdram_arbiter: RTL and testbench

- Shares the single 32-bit SDRAM controller port (addr/data/we/req/ack/valid/q) between NUM_PORTS read-only ROM requesters and the ROM download write path.
- Typical read requesters: CPU program ROM, character/foreground/background tile ROMs and sprite ROM.
- Sits between those ROM fetch blocks and the sdram controller inside the game core, on the system clock.
- Keeps one transaction outstanding at a time. Download writes take absolute priority; reads are granted round-robin.

---
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 tb/tb_sdram_arbiter.sv | 559 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between NUM_PORTS ROM readers and the download write path.
// Writes always win; reads are granted round-robin, one transaction outstanding at a time.
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS-1:0]            port_req,
    output logic [NUM_PORTS-1:0]            port_ack,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [DATA_WIDTH-1:0]           port_data,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_req,
    output logic                            wr_ack,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state_q;
    logic [NUM_PORTS-1:0]    grant_q;
    logic                    write_q;
    logic [PW-1:0]           rr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    we_q;
    logic                    req_q;

    logic                    pickFound_d;
    logic [PW-1:0]           pickIdx_d;
    logic [PW-1:0]           candIdx;
    logic [ADDR_WIDTH-1:0]   pickAddr_d;

    // Search starts just after the last granted port so every requester gets its turn.
    always_comb begin
        pickFound_d = 1'b0;
        pickIdx_d   = '0;
        candIdx     = '0;
        pickAddr_d  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            candIdx = PW'((int'(rr_q) + i) % NUM_PORTS);
            if (!pickFound_d && port_req[candIdx]) begin
                pickFound_d = 1'b1;
                pickIdx_d   = candIdx;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pickIdx_d == PW'(i)) begin
                pickAddr_d = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            write_q <= 1'b0;
            rr_q    <= PW'(NUM_PORTS - 1);
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        addr_q  <= wr_addr;
                        data_q  <= wr_data;
                        we_q    <= 1'b1;
                        write_q <= 1'b1;
                        grant_q <= '0;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end else if (pickFound_d) begin
                        addr_q  <= pickAddr_d;
                        we_q    <= 1'b0;
                        write_q <= 1'b0;
                        grant_q <= NUM_PORTS'(1) << pickIdx_d;
                        rr_q    <= pickIdx_d;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_q <= 1'b0;
                        if (write_q) begin
                            write_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (sdram_valid) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake pulses are gated by state so stray controller strobes never reach a requester.
    assign port_ack   = (state_q == REQ && sdram_ack && !write_q) ? grant_q : '0;
    assign wr_ack     = (state_q == REQ) && sdram_ack && write_q;
    assign port_valid = (state_q == WAIT && sdram_valid) ? grant_q : '0;
    assign port_data  = sdram_q;

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_we   = we_q;
    assign sdram_req  = req_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomised checks for sdram_arbiter against a small SDRAM controller model.
module tb_sdram_arbiter;
    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam logic [AW-1:0] WBASE = 23'h040000;
    localparam int NUM_WRITES = 200;
    localparam int RD_TARGET = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [AW-1:0]    pAddr [NP];
    logic [NP*AW-1:0] port_addr;
    logic [NP-1:0]    port_req, port_ack, port_valid;
    logic [DW-1:0]    port_data;
    logic [AW-1:0]    wr_addr, sdram_addr;
    logic [DW-1:0]    wr_data, sdram_data, sdram_q;
    logic             wr_req, wr_ack, sdram_we, sdram_req, sdram_ack, sdram_valid;

    logic             ctrlEn, randDelays;
    logic             autoAck, autoValid, manAck, manValid;
    logic [DW-1:0]    autoQ, manQ;

    int testsRun, testsFailed;

    for (genvar g = 0; g < NP; g++) begin : g_addr
        assign port_addr[g*AW +: AW] = pAddr[g];
    end

    assign sdram_ack   = ctrlEn ? autoAck   : manAck;
    assign sdram_valid = ctrlEn ? autoValid : manValid;
    assign sdram_q     = ctrlEn ? autoQ     : manQ;

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .port_addr(port_addr), .port_req(port_req), .port_ack(port_ack),
        .port_valid(port_valid), .port_data(port_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .sdram_q(sdram_q)
    );

    function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] wrWord(input int k);
        return 32'hA500_0000 + DW'(k) * 32'h0001_0003;
    endfunction

    // Controller model: acks a pending request, then returns ROM data for reads only.
    initial begin : controller
        logic [AW-1:0] cAddr;
        logic          cWe;
        int            ackD, valD;
        autoAck = 1'b0;
        autoValid = 1'b0;
        autoQ = '0;
        forever begin
            @(negedge clk);
            if (ctrlEn && sdram_req) begin
                cAddr = sdram_addr;
                cWe   = sdram_we;
                ackD  = randDelays ? int'($urandom_range(0, 5)) : 0;
                valD  = randDelays ? int'($urandom_range(0, 5)) : 1;
                repeat (ackD) @(negedge clk);
                autoAck = 1'b1;
                @(negedge clk);
                autoAck = 1'b0;
                if (!cWe) begin
                    repeat (valD) @(negedge clk);
                    autoValid = 1'b1;
                    autoQ = romWord(cAddr);
                    @(negedge clk);
                    autoValid = 1'b0;
                end
            end
        end
    end

    task automatic applyReset();
        reset_n = 1'b0;
        port_req = '0;
        wr_req = 1'b0;
        manAck = 1'b0;
        manValid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        port_req = 4'hF;
        manAck = 1'b1;
        manValid = 1'b1;
        manQ = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        testsRun++;
        if (sdram_req !== 1'b0 || sdram_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_req_we: got req=%b we=%b, expected 0 0", sdram_req, sdram_we);
        end
        testsRun++;
        if (sdram_addr !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_addr: got %h, expected 0", sdram_addr);
        end
        testsRun++;
        if (sdram_data !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h, expected 0", sdram_data);
        end
        testsRun++;
        if (port_ack !== '0 || wr_ack !== 1'b0 || port_valid !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_handshakes: got ack=%b wr_ack=%b valid=%b, expected all 0", port_ack, wr_ack, port_valid);
        end
        testsRun++;
        if (port_data !== 32'hCAFE_F00D) begin
            testsFailed++;
            $display("[TB] FAIL data_passthrough: got %h, expected cafef00d", port_data);
        end
        applyReset();
    endtask

    task automatic test_single_read();
        for (int i = 0; i < NP; i++) pAddr[i[1:0]] = 23'h0AAAA0 + AW'(i);
        pAddr[2] = 23'h001234;
        @(negedge clk);
        port_req = 4'b0100;
        #1;
        testsRun++;
        if (sdram_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_req_early: got %b, expected 0", sdram_req);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (sdram_req !== 1'b1 || sdram_addr !== 23'h001234 || sdram_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_issue: got req=%b addr=%h we=%b, expected 1 001234 0", sdram_req, sdram_addr, sdram_we);
        end
        @(negedge clk);
        manAck = 1'b1;
        #1;
        testsRun++;
        if (port_ack !== 4'b0100 || wr_ack !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_ack: got ack=%b wr_ack=%b, expected 0100 0", port_ack, wr_ack);
        end
        @(negedge clk);
        manAck = 1'b0;
        port_req = '0;
        #1;
        testsRun++;
        if (sdram_req !== 1'b0 || port_ack !== '0) begin
            testsFailed++;
            $display("[TB] FAIL read_req_drop: got req=%b ack=%b, expected 0 0000", sdram_req, port_ack);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if (port_valid !== '0) begin
            testsFailed++;
            $display("[TB] FAIL read_no_early_valid: got %b, expected 0000", port_valid);
        end
        @(negedge clk);
        manValid = 1'b1;
        manQ = 32'hDEAD_BEEF;
        #1;
        testsRun++;
        if (port_valid !== 4'b0100 || port_data !== 32'hDEAD_BEEF) begin
            testsFailed++;
            $display("[TB] FAIL read_valid: got valid=%b data=%h, expected 0100 deadbeef", port_valid, port_data);
        end
        @(negedge clk);
        manValid = 1'b0;
        #1;
        testsRun++;
        if (port_valid !== '0 || sdram_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_done: got valid=%b req=%b, expected 0000 0", port_valid, sdram_req);
        end
    endtask

    task automatic test_round_robin();
        int got [6];
        int n, idx, cnt;
        applyReset();
        ctrlEn = 1'b1;
        randDelays = 1'b0;
        for (int i = 0; i < NP; i++) pAddr[i[1:0]] = 23'h100000 + AW'(i) * 23'h111;
        port_req = 4'hF;
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 6; cyc++) begin
            @(negedge clk);
            #2;
            if (port_ack !== '0) begin
                idx = -1;
                cnt = 0;
                for (int i = 0; i < NP; i++) begin
                    if (port_ack[i[1:0]]) begin
                        idx = i;
                        cnt++;
                    end
                end
                if (cnt != 1) idx = -1;
                got[n] = idx;
                n++;
                if (idx >= 0) begin
                    testsRun++;
                    if (sdram_addr !== pAddr[idx[1:0]]) begin
                        testsFailed++;
                        $display("[TB] FAIL rr_addr: got %h, expected %h", sdram_addr, pAddr[idx[1:0]]);
                    end
                end
            end
        end
        testsRun++;
        if (n != 6) begin
            testsFailed++;
            $display("[TB] FAIL rr_timeout: got %0d grants, expected 6", n);
        end
        for (int k = 0; k < n; k++) begin
            testsRun++;
            if (got[k] != k % NP) begin
                testsFailed++;
                $display("[TB] FAIL rr_order[%0d]: got port %0d, expected port %0d", k, got[k], k % NP);
            end
        end
        port_req = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_write_priority();
        int ev [8];
        int evN, validN, idx;
        logic wrDrop;
        logic [NP-1:0] dropP;
        applyReset();
        ctrlEn = 1'b1;
        randDelays = 1'b0;
        evN = 0;
        validN = 0;
        wrDrop = 1'b0;
        dropP = '0;
        pAddr[0] = 23'h000200;
        pAddr[1] = 23'h000300;
        wr_addr = 23'h000010;
        wr_data = 32'h1122_3344;
        wr_req = 1'b1;
        port_req = 4'b0011;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (wrDrop) wr_req = 1'b0;
            port_req = port_req & ~dropP;
            wrDrop = 1'b0;
            dropP = '0;
            #2;
            if (wr_ack) begin
                if (evN < 8) ev[evN] = -1;
                evN++;
                wrDrop = 1'b1;
                testsRun++;
                if (sdram_we !== 1'b1 || sdram_addr !== 23'h000010 || sdram_data !== 32'h1122_3344) begin
                    testsFailed++;
                    $display("[TB] FAIL write_bus: got we=%b addr=%h data=%h, expected 1 000010 11223344", sdram_we, sdram_addr, sdram_data);
                end
            end
            if (port_ack !== '0) begin
                idx = port_ack[0] ? 0 : port_ack[1] ? 1 : port_ack[2] ? 2 : 3;
                if (evN < 8) ev[evN] = idx;
                evN++;
                dropP = port_ack;
            end
            if (port_valid !== '0) validN++;
        end
        testsRun++;
        if (evN != 3) begin
            testsFailed++;
            $display("[TB] FAIL wp_count: got %0d accepts, expected 3", evN);
        end else begin
            testsRun++;
            if (ev[0] != -1 || ev[1] != 0 || ev[2] != 1) begin
                testsFailed++;
                $display("[TB] FAIL wp_order: got %0d,%0d,%0d, expected -1,0,1", ev[0], ev[1], ev[2]);
            end
        end
        testsRun++;
        if (validN != 2) begin
            testsFailed++;
            $display("[TB] FAIL wp_valids: got %0d, expected 2", validN);
        end
    endtask

    task automatic test_stray();
        applyReset();
        ctrlEn = 1'b0;
        @(negedge clk);
        manAck = 1'b1;
        #1;
        testsRun++;
        if (port_ack !== '0 || wr_ack !== 1'b0 || sdram_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stray_ack_idle: got ack=%b wr_ack=%b req=%b, expected 0000 0 0", port_ack, wr_ack, sdram_req);
        end
        @(negedge clk);
        manAck = 1'b0;
        #1;
        testsRun++;
        if (sdram_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stray_ack_state: got req=%b, expected 0", sdram_req);
        end
        @(negedge clk);
        pAddr[1] = 23'h0ABCDE;
        port_req = 4'b0010;
        @(negedge clk);
        manValid = 1'b1;
        manQ = 32'h55AA_55AA;
        #1;
        testsRun++;
        if (sdram_req !== 1'b1 || port_valid !== '0) begin
            testsFailed++;
            $display("[TB] FAIL stray_valid_req: got req=%b valid=%b, expected 1 0000", sdram_req, port_valid);
        end
        @(negedge clk);
        manValid = 1'b0;
        #1;
        testsRun++;
        if (sdram_req !== 1'b1 || sdram_addr !== 23'h0ABCDE) begin
            testsFailed++;
            $display("[TB] FAIL stray_valid_state: got req=%b addr=%h, expected 1 0abcde", sdram_req, sdram_addr);
        end
        @(negedge clk);
        manAck = 1'b1;
        #1;
        testsRun++;
        if (port_ack !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL stray_real_ack: got %b, expected 0010", port_ack);
        end
        @(negedge clk);
        manAck = 1'b0;
        port_req = '0;
        @(negedge clk);
        manValid = 1'b1;
        manQ = 32'h0BAD_F00D;
        #1;
        testsRun++;
        if (port_valid !== 4'b0010 || port_data !== 32'h0BAD_F00D) begin
            testsFailed++;
            $display("[TB] FAIL stray_real_valid: got valid=%b data=%h, expected 0010 0badf00d", port_valid, port_data);
        end
        @(negedge clk);
        manValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        applyReset();
        ctrlEn = 1'b0;
        pAddr[0] = 23'h000100;
        pAddr[3] = 23'h003300;
        @(negedge clk);
        port_req = 4'b1000;
        @(negedge clk);
        manAck = 1'b1;
        #1;
        testsRun++;
        if (port_ack !== 4'b1000 || sdram_addr !== 23'h003300) begin
            testsFailed++;
            $display("[TB] FAIL rm_ack: got ack=%b addr=%h, expected 1000 003300", port_ack, sdram_addr);
        end
        @(negedge clk);
        manAck = 1'b0;
        port_req = '0;
        #1;
        reset_n = 1'b0;
        manValid = 1'b1;
        #1;
        testsRun++;
        if (sdram_req !== 1'b0 || sdram_addr !== '0 || port_valid !== '0 || port_ack !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rm_async: got req=%b addr=%h valid=%b ack=%b, expected 0 0 0000 0000", sdram_req, sdram_addr, port_valid, port_ack);
        end
        @(negedge clk);
        reset_n = 1'b1;
        manValid = 1'b0;
        @(negedge clk);
        manValid = 1'b1;
        #1;
        testsRun++;
        if (port_valid !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rm_stale_valid: got %b, expected 0000", port_valid);
        end
        @(negedge clk);
        manValid = 1'b0;
        port_req = 4'b1001;
        @(negedge clk);
        #1;
        testsRun++;
        if (sdram_req !== 1'b1 || sdram_addr !== 23'h000100) begin
            testsFailed++;
            $display("[TB] FAIL rm_tie: got req=%b addr=%h, expected 1 000100", sdram_req, sdram_addr);
        end
        manAck = 1'b1;
        #1;
        testsRun++;
        if (port_ack !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL rm_tie_ack: got %b, expected 0001", port_ack);
        end
        @(negedge clk);
        manAck = 1'b0;
        port_req = 4'b1000;
        @(negedge clk);
        manValid = 1'b1;
        manQ = 32'h00C0_FFEE;
        @(negedge clk);
        manValid = 1'b0;
        @(negedge clk);
        #1;
        testsRun++;
        if (sdram_req !== 1'b1 || sdram_addr !== 23'h003300) begin
            testsFailed++;
            $display("[TB] FAIL rm_port3_issue: got req=%b addr=%h, expected 1 003300", sdram_req, sdram_addr);
        end
        manAck = 1'b1;
        @(negedge clk);
        manAck = 1'b0;
        port_req = '0;
        @(negedge clk);
        manValid = 1'b1;
        manQ = 32'h3333_3333;
        #1;
        testsRun++;
        if (port_valid !== 4'b1000 || port_data !== 32'h3333_3333) begin
            testsFailed++;
            $display("[TB] FAIL rm_port3_valid: got valid=%b data=%h, expected 1000 33333333", port_valid, port_data);
        end
        @(negedge clk);
        manValid = 1'b0;
    endtask

    task automatic test_random();
        int wrIssued, wrAcked, rdIssued, rdDone, cyc;
        logic wrDrop, wrDropped;
        logic [NP-1:0] dropP, pend;
        logic [AW-1:0] rdA [NP];
        applyReset();
        ctrlEn = 1'b1;
        randDelays = 1'b1;
        wrIssued = 0;
        wrAcked = 0;
        rdIssued = 0;
        rdDone = 0;
        wrDrop = 1'b0;
        dropP = '0;
        pend = '0;
        for (int i = 0; i < NP; i++) rdA[i[1:0]] = '0;
        cyc = 0;
        while (cyc < 40000 && !(wrAcked == NUM_WRITES && rdIssued >= RD_TARGET && rdDone == rdIssued
                                && wr_req == 1'b0 && port_req == '0)) begin
            cyc++;
            @(negedge clk);
            wrDropped = wrDrop;
            if (wrDrop) wr_req = 1'b0;
            wrDrop = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (dropP[p[1:0]]) begin
                    port_req[p[1:0]] = 1'b0;
                end else if (!port_req[p[1:0]] && !pend[p[1:0]] && rdIssued < RD_TARGET
                             && $urandom_range(0, 3) == 0) begin
                    rdA[p[1:0]] = AW'($urandom);
                    pAddr[p[1:0]] = rdA[p[1:0]];
                    port_req[p[1:0]] = 1'b1;
                    rdIssued++;
                end
            end
            dropP = '0;
            if (!wr_req && !wrDropped && wrIssued < NUM_WRITES && $urandom_range(0, 2) == 0) begin
                wr_addr = WBASE + AW'(wrIssued);
                wr_data = wrWord(wrIssued);
                wr_req = 1'b1;
                wrIssued++;
            end
            #2;
            if (wr_ack) begin
                testsRun++;
                if (sdram_we !== 1'b1 || sdram_addr !== WBASE + AW'(wrAcked) || sdram_data !== wrWord(wrAcked)) begin
                    testsFailed++;
                    $display("[TB] FAIL write_order #%0d: got we=%b addr=%h data=%h, expected 1 %h %h",
                             wrAcked, sdram_we, sdram_addr, sdram_data, WBASE + AW'(wrAcked), wrWord(wrAcked));
                end
                wrAcked++;
                wrDrop = 1'b1;
            end
            for (int p = 0; p < NP; p++) begin
                if (port_ack[p[1:0]]) begin
                    pend[p[1:0]] = 1'b1;
                    dropP[p[1:0]] = 1'b1;
                    testsRun++;
                    if (sdram_addr !== rdA[p[1:0]] || sdram_we !== 1'b0) begin
                        testsFailed++;
                        $display("[TB] FAIL read_issue port %0d: got addr=%h we=%b, expected %h 0", p, sdram_addr, sdram_we, rdA[p[1:0]]);
                    end
                end
                if (port_valid[p[1:0]]) begin
                    testsRun++;
                    if (!pend[p[1:0]] || port_data !== romWord(rdA[p[1:0]])) begin
                        testsFailed++;
                        $display("[TB] FAIL read_data port %0d: got pend=%b data=%h, expected 1 %h", p, pend[p[1:0]], port_data, romWord(rdA[p[1:0]]));
                    end
                    pend[p[1:0]] = 1'b0;
                    rdDone++;
                end
            end
        end
        testsRun++;
        if (wrAcked != NUM_WRITES || rdDone != rdIssued || rdIssued < RD_TARGET) begin
            testsFailed++;
            $display("[TB] FAIL random_complete: got writes=%0d reads=%0d/%0d, expected %0d and %0d/%0d",
                     wrAcked, rdDone, rdIssued, NUM_WRITES, RD_TARGET, RD_TARGET);
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        ctrlEn = 1'b0;
        randDelays = 1'b0;
        manAck = 1'b0;
        manValid = 1'b0;
        manQ = '0;
        port_req = '0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NP; i++) pAddr[i[1:0]] = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_stray();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
